// File: rtl/instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// instr_fetch_reg
// Instruction fetch sequencer plus instruction register (IR). It issues one
// request per fetch to the instruction memory, waits a variable latency for
// the in-order response, latches the 32-bit instruction with its PC and
// exposes the decoded register/opcode fields to the sign-extender and the
// control unit. It supports flush, fetch timeout and misaligned-PC reporting.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   fetch_en     in   control unit requests a fetch at pc_in (ignored when busy)
//   pc_in        in   64-bit fetch address
//   flush        in   abandon any in-flight fetch
//   imem_req     out  one-cycle request strobe to instruction memory
//   imem_addr    out  registered request address
//   imem_rdata   in   memory response data
//   imem_valid   in   response strobe, responses return in order
//   instr        out  IR contents
//   instr_pc     out  PC of the instruction held in the IR
//   opcode/rd/funct3/rs1/rs2/funct7  out  combinational slices of the IR
//   instr_valid  out  one-cycle pulse when the IR has been newly loaded
//   busy         out  high while a fetch is in progress (REQ or WAIT)
//   misaligned   out  one-cycle pulse after fetch_en with pc_in[1:0] != 0
//   fetch_err    out  one-cycle pulse after a fetch timed out
// -----------------------------------------------------------------------------
module instr_fetch_reg #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   input  logic [63:0] pc_in,
   input  logic        flush,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic        instr_valid,
   output logic        busy,
   output logic        misaligned,
   output logic        fetch_err
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [31:0]   r_instr;
   logic [63:0]   r_instr_pc;
   logic [63:0]   r_imem_addr;
   logic [CW-1:0] r_cnt;
   logic          r_drop;        // one stale response still owed by memory
   logic          r_instr_valid;
   logic          r_misaligned;
   logic          r_fetch_err;

   logic [CW-1:0] w_cnt_inc;
   logic          w_fetch_ok;
   logic          w_misalign;
   logic          w_accept;
   logic          w_timeout;

   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_fetch_ok = (r_state == S_IDLE) && fetch_en && (pc_in[1:0] == 2'b00);
   assign w_misalign = (r_state == S_IDLE) && fetch_en && (pc_in[1:0] != 2'b00);
   // A response is only ours when no stale one is outstanding and no flush
   // is abandoning the fetch in the same cycle.
   assign w_accept   = (r_state == S_WAIT) && imem_valid && !r_drop && !flush;
   // Flush wins over timeout; a discarded stale response does not count as
   // an accepted one, so the timeout can still fire in that cycle.
   assign w_timeout  = (r_state == S_WAIT) && !flush && !w_accept &&
                       (w_cnt_inc == TO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_fetch_ok) w_next = S_REQ;
         S_REQ:   w_next = flush ? S_IDLE : S_WAIT;
         S_WAIT:  if (flush || w_accept || w_timeout) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      imem_req = (r_state == S_REQ);
      busy     = (r_state != S_IDLE);
   end

   // IR, address, counter, stale tracking and registered pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= RESET_PC;
         r_imem_addr   <= 64'h0;
         r_cnt         <= '0;
         r_drop        <= 1'b0;
         r_instr_valid <= 1'b0;
         r_misaligned  <= 1'b0;
         r_fetch_err   <= 1'b0;
      end else begin
         r_instr_valid <= w_accept;
         r_misaligned  <= w_misalign;
         r_fetch_err   <= w_timeout;

         if (w_fetch_ok) r_imem_addr <= pc_in;

         if (w_accept) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_imem_addr;
         end

         if (r_state == S_REQ)       r_cnt <= '0;
         else if (r_state == S_WAIT) r_cnt <= w_cnt_inc;

         case (r_state)
            S_IDLE: begin
               if (imem_valid) r_drop <= 1'b0;
            end
            S_REQ: begin
               // The request goes out even when flushed, so its reply is owed.
               if (flush)           r_drop <= 1'b1;
               else if (imem_valid) r_drop <= 1'b0;
            end
            S_WAIT: begin
               if (flush) begin
                  // With a simultaneous response the reply is consumed here.
                  if (!imem_valid) r_drop <= 1'b1;
               end else if (w_timeout) begin
                  r_drop <= 1'b1;
               end else if (imem_valid) begin
                  r_drop <= 1'b0;
               end
            end
            default: r_drop <= r_drop;
         endcase
      end
   end

   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign imem_addr   = r_imem_addr;
   assign instr_valid = r_instr_valid;
   assign misaligned  = r_misaligned;
   assign fetch_err   = r_fetch_err;

   assign opcode = r_instr[6:0];
   assign rd     = r_instr[11:7];
   assign funct3 = r_instr[14:12];
   assign rs1    = r_instr[19:15];
   assign rs2    = r_instr[24:20];
   assign funct7 = r_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_reg
// Directed bench for instr_fetch_reg. A fetch-transaction model tracks whether
// a fetch is outstanding, how long it has waited and how many stale replies
// memory still owes; a negedge process compares every output against it each
// cycle. Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_instr_fetch_reg;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [63:0] pc_in;
   logic        flush;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic        instr_valid;
   logic        busy;
   logic        misaligned;
   logic        fetch_err;

   always #5 clk = ~clk;

   instr_fetch_reg #(
      .RESET_PC  (64'h0),
      .TIMEOUT   (TIMEOUT),
      .NOP_INSTR (32'h00000013)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_en    (fetch_en),
      .pc_in       (pc_in),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .rd          (rd),
      .funct3      (funct3),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct7      (funct7),
      .instr_valid (instr_valid),
      .busy        (busy),
      .misaligned  (misaligned),
      .fetch_err   (fetch_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- fetch-transaction model ----------------
   logic        m_active;   // a fetch is outstanding (request or waiting)
   logic        m_req;      // the request strobe is due this cycle
   int          m_age;      // wait cycles already spent on this fetch
   int          m_stale;    // replies memory still owes to abandoned fetches
   logic [63:0] e_addr;
   logic [63:0] e_pc;
   logic [31:0] e_instr;
   logic        e_ivld;
   logic        e_mis;
   logic        e_err;

   always @(posedge clk) begin
      if (reset) begin
         m_active <= 1'b0;
         m_req    <= 1'b0;
         m_age    <= 0;
         m_stale  <= 0;
         e_addr   <= 64'h0;
         e_pc     <= 64'h0;
         e_instr  <= 32'h00000013;
         e_ivld   <= 1'b0;
         e_mis    <= 1'b0;
         e_err    <= 1'b0;
      end else begin
         e_ivld <= 1'b0;
         e_mis  <= 1'b0;
         e_err  <= 1'b0;
         if (!m_active) begin
            if (imem_valid && m_stale > 0) m_stale <= m_stale - 1;
            if (fetch_en) begin
               if (pc_in[1:0] != 2'b00) e_mis <= 1'b1;
               else begin
                  m_active <= 1'b1;
                  m_req    <= 1'b1;
                  e_addr   <= pc_in;
               end
            end
         end else if (m_req) begin
            m_req <= 1'b0;
            m_age <= 0;
            if (flush) begin
               m_active <= 1'b0;
               m_stale  <= ((imem_valid && m_stale > 0) ? m_stale - 1 : m_stale) + 1;
            end else if (imem_valid && m_stale > 0) begin
               m_stale <= m_stale - 1;
            end
         end else begin
            if (flush) begin
               m_active <= 1'b0;
               if (!imem_valid) m_stale <= m_stale + 1;
            end else if (imem_valid && m_stale == 0) begin
               e_instr  <= imem_rdata;
               e_pc     <= e_addr;
               e_ivld   <= 1'b1;
               m_active <= 1'b0;
            end else if (m_age + 1 == TIMEOUT) begin
               e_err    <= 1'b1;
               m_active <= 1'b0;
               m_stale  <= (imem_valid ? m_stale - 1 : m_stale) + 1;
            end else begin
               m_age <= m_age + 1;
               if (imem_valid) m_stale <= m_stale - 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy",        64'(busy),        64'(m_active));
         chk("imem_req",    64'(imem_req),    64'(m_req));
         chk("imem_addr",   imem_addr,        e_addr);
         chk("instr",       64'(instr),       64'(e_instr));
         chk("instr_pc",    instr_pc,         e_pc);
         chk("instr_valid", 64'(instr_valid), 64'(e_ivld));
         chk("misaligned",  64'(misaligned),  64'(e_mis));
         chk("fetch_err",   64'(fetch_err),   64'(e_err));
         chk("opcode",      64'(opcode),      64'(e_instr[6:0]));
         chk("rd",          64'(rd),          64'(e_instr[11:7]));
         chk("funct3",      64'(funct3),      64'(e_instr[14:12]));
         chk("rs1",         64'(rs1),         64'(e_instr[19:15]));
         chk("rs2",         64'(rs2),         64'(e_instr[24:20]));
         chk("funct7",      64'(funct7),      64'(e_instr[31:25]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Aligned fetch answered one cycle after the request.
   task automatic fetch_ok(input logic [63:0] a, input logic [31:0] d);
      fetch_en = 1'b1; pc_in = a;
      cyc();
      fetch_en = 1'b0;
      cyc();
      imem_valid = 1'b1; imem_rdata = d;
      cyc();
      imem_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; fetch_en = 1'b0; pc_in = 64'h0; flush = 1'b0;
      imem_valid = 1'b0; imem_rdata = 32'h0;
      cyc();
      cyc();
      chk_on = 1'b1;
      reset  = 1'b0;

      // Reset state
      chk("lit_rst_instr",  64'(instr),       64'h13);
      chk("lit_rst_opcode", 64'(opcode),      64'h13);
      chk("lit_rst_pc",     instr_pc,         64'h0);
      chk("lit_rst_ivld",   64'(instr_valid), 64'h0);
      chk("lit_rst_busy",   64'(busy),        64'h0);
      cyc();

      // Minimum-latency fetch at 0x40
      fetch_en = 1'b1; pc_in = 64'h40;
      cyc();
      fetch_en = 1'b0;
      chk("lit_f1_req",  64'(imem_req), 64'h1);
      chk("lit_f1_addr", imem_addr,     64'h40);
      cyc();
      imem_valid = 1'b1; imem_rdata = 32'hFE010113;
      chk("lit_f1_req_done", 64'(imem_req), 64'h0);
      cyc();
      imem_valid = 1'b0;
      chk("lit_f1_instr", 64'(instr),       64'hFE010113);
      chk("lit_f1_rs1",   64'(rs1),         64'h2);
      chk("lit_f1_rd",    64'(rd),          64'h2);
      chk("lit_f1_ivld",  64'(instr_valid), 64'h1);
      chk("lit_f1_pc",    instr_pc,         64'h40);
      cyc();
      chk("lit_f1_ivld_off", 64'(instr_valid), 64'h0);

      // Misaligned request
      fetch_en = 1'b1; pc_in = 64'h42;
      cyc();
      fetch_en = 1'b0;
      chk("lit_mis_pulse", 64'(misaligned), 64'h1);
      chk("lit_mis_noreq", 64'(imem_req),   64'h0);
      chk("lit_mis_ir",    64'(instr),      64'hFE010113);
      cyc();
      chk("lit_mis_off",   64'(misaligned), 64'h0);
      flush = 1'b1;               // flush in IDLE: no effect
      cyc();
      flush = 1'b0;

      // Flush in WAIT, refetch, stale response dropped
      fetch_en = 1'b1; pc_in = 64'h80;
      cyc();
      fetch_en = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("lit_fl_busy", 64'(busy), 64'h0);
      fetch_en = 1'b1; pc_in = 64'h84;
      cyc();
      fetch_en = 1'b0;
      cyc();
      imem_valid = 1'b1; imem_rdata = 32'h00A00093;
      cyc();
      imem_rdata = 32'h00100513;
      chk("lit_fl_stale_ir",   64'(instr),       64'hFE010113);
      chk("lit_fl_stale_ivld", 64'(instr_valid), 64'h0);
      cyc();
      imem_valid = 1'b0;
      chk("lit_fl_instr", 64'(instr),       64'h00100513);
      chk("lit_fl_pc",    instr_pc,         64'h84);
      chk("lit_fl_ivld",  64'(instr_valid), 64'h1);
      chk("lit_fl_rd",    64'(rd),          64'd10);
      cyc();

      // Timeout, then a late response that must be dropped
      fetch_en = 1'b1; pc_in = 64'h100;
      cyc();
      fetch_en = 1'b0;
      repeat (TIMEOUT) cyc();
      chk("lit_to_busy_last", 64'(busy),      64'h1);
      chk("lit_to_err_early", 64'(fetch_err), 64'h0);
      cyc();
      chk("lit_to_err",  64'(fetch_err), 64'h1);
      chk("lit_to_busy", 64'(busy),      64'h0);
      cyc();
      chk("lit_to_err_off", 64'(fetch_err), 64'h0);
      cyc();
      imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
      cyc();
      imem_valid = 1'b0;
      chk("lit_to_late_ir",   64'(instr),       64'h00100513);
      chk("lit_to_late_ivld", 64'(instr_valid), 64'h0);
      fetch_ok(64'h200, 32'h002081B3);
      chk("lit_to_next_ir", 64'(instr), 64'h002081B3);
      chk("lit_to_next_rd", 64'(rd),    64'h3);
      cyc();

      // Flush during REQ: request still issued, its reply arrives in IDLE
      fetch_en = 1'b1; pc_in = 64'h400;
      cyc();
      fetch_en = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("lit_rq_busy", 64'(busy), 64'h0);
      imem_valid = 1'b1; imem_rdata = 32'hBADBAD00;
      cyc();
      imem_valid = 1'b0;
      chk("lit_rq_ir", 64'(instr), 64'h002081B3);
      fetch_ok(64'h404, 32'h40208233);
      chk("lit_rq_f7",  64'(funct7), 64'h20);
      chk("lit_rq_rs2", 64'(rs2),    64'h2);
      chk("lit_rq_rs1", 64'(rs1),    64'h1);
      chk("lit_rq_pc",  instr_pc,    64'h404);
      cyc();

      // Reset during WAIT
      fetch_en = 1'b1; pc_in = 64'h300;
      cyc();
      fetch_en = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("lit_rw_busy",  64'(busy),        64'h0);
      chk("lit_rw_instr", 64'(instr),       64'h13);
      chk("lit_rw_pc",    instr_pc,         64'h0);
      chk("lit_rw_addr",  imem_addr,        64'h0);
      chk("lit_rw_ivld",  64'(instr_valid), 64'h0);
      chk("lit_rw_err",   64'(fetch_err),   64'h0);
      cyc();
      chk("lit_rw_ivld2", 64'(instr_valid), 64'h0);
      chk("lit_rw_err2",  64'(fetch_err),   64'h0);
      cyc();
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
